// File: rtl/cardio_pkg.sv
// Shared types and constants for the CardioAnalyseIP register arbiter.
// AXI response codes, arbiter FSM states, register map geometry.
package cardio_pkg;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'b00,
    AXI_EXOKAY = 2'b01,
    AXI_SLVERR = 2'b10,
    AXI_DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_AW_W,
    ST_WR_B,
    ST_RD_AR,
    ST_RD_R,
    ST_LOCAL_ERR,
    ST_DONE
  } arb_state_t;

  localparam int CARDIO_NUM_REGS   = 4;
  localparam int CARDIO_REG_STRIDE = 4;

endpackage

// File: rtl/cardio_rr_arb2.sv
// Two-way round-robin grant with a last-granted register.
// Ports: clk, rst_n (sync), req[1:0], take -> gnt_valid, gnt_idx.
module cardio_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic last;

  // last resets to 1 so requester 0 wins the first contended grant
  always_comb begin
    gnt_valid = |req;
    gnt_idx   = (req == 2'b11) ? ~last : req[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (take && gnt_valid) begin
      last <= gnt_idx;
    end
  end

endmodule

// File: rtl/cardio_axil_arbiter.sv
// Shares one AXI4-Lite register slave between two req/ack requesters.
// Ports: ACLK/ARESETN, req/we/addr/wdata/wstrb -> ack/rdata/resp, m_axi_*.
module cardio_axil_arbiter
  import cardio_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int NUM_REGS = CARDIO_NUM_REGS
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [63:0]         wdata,
  input  logic [7:0]          wstrb,
  output logic [1:0]          ack,
  output logic [31:0]         rdata,
  output logic [1:0]          resp,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [31:0]         m_axi_wdata,
  output logic [3:0]          m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [2:0]          m_axi_arprot,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [31:0]         m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  localparam logic [ADDR_W:0] ADDR_LIMIT =
    (ADDR_W+1)'(NUM_REGS * CARDIO_REG_STRIDE);

  arb_state_t          state;
  logic                gnt;
  logic                issued;
  logic [ADDR_W-1:0]   l_addr;
  logic [31:0]         l_wdata;
  logic [3:0]          l_wstrb;

  logic                gnt_valid;
  logic                gnt_idx;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [31:0]         sel_wdata;
  logic [3:0]          sel_wstrb;
  logic                bad_addr;
  logic                aw_fin;
  logic                w_fin;
  logic [1:0]          ack_vec;

  cardio_rr_arb2 u_rr (
    .clk       (ACLK),
    .rst_n     (ARESETN),
    .req       (req),
    .take      (state == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    sel_we    = gnt_idx ? we[1] : we[0];
    sel_addr  = gnt_idx ? addr[2*ADDR_W-1:ADDR_W]
                        : addr[ADDR_W-1:0];
    sel_wdata = gnt_idx ? wdata[63:32] : wdata[31:0];
    sel_wstrb = gnt_idx ? wstrb[7:4] : wstrb[3:0];
    bad_addr  = ({1'b0, sel_addr} >= ADDR_LIMIT) ||
                (sel_addr[1:0] != 2'b00);
    // a channel is finished once its valid is low or handshaking now
    aw_fin    = !m_axi_awvalid || m_axi_awready;
    w_fin     = !m_axi_wvalid || m_axi_wready;
    ack_vec   = gnt ? 2'b10 : 2'b01;
  end

  assign m_axi_awaddr = l_addr;
  assign m_axi_araddr = l_addr;
  assign m_axi_wdata  = l_wdata;
  assign m_axi_wstrb  = l_wstrb;
  assign m_axi_awprot = 3'b000;
  assign m_axi_arprot = 3'b000;

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state         <= ST_IDLE;
      gnt           <= 1'b0;
      issued        <= 1'b0;
      l_addr        <= '0;
      l_wdata       <= '0;
      l_wstrb       <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      ack           <= '0;
      rdata         <= '0;
      resp          <= '0;
    end else begin
      ack <= '0;
      unique case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt     <= gnt_idx;
            l_addr  <= sel_addr;
            l_wdata <= sel_wdata;
            l_wstrb <= sel_wstrb;
            issued  <= 1'b0;
            if (bad_addr)    state <= ST_LOCAL_ERR;
            else if (sel_we) state <= ST_WR_AW_W;
            else             state <= ST_RD_AR;
          end
        end
        ST_WR_AW_W: begin
          // valids launch one cycle after entry
          if (!issued) begin
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            issued        <= 1'b1;
          end else begin
            if (m_axi_awvalid && m_axi_awready)
              m_axi_awvalid <= 1'b0;
            if (m_axi_wvalid && m_axi_wready)
              m_axi_wvalid <= 1'b0;
            if (aw_fin && w_fin) begin
              m_axi_bready <= 1'b1;
              state        <= ST_WR_B;
            end
          end
        end
        ST_WR_B: begin
          if (m_axi_bvalid) begin
            resp         <= m_axi_bresp;
            m_axi_bready <= 1'b0;
            ack          <= ack_vec;
            state        <= ST_DONE;
          end
        end
        ST_RD_AR: begin
          if (!issued) begin
            m_axi_arvalid <= 1'b1;
            issued        <= 1'b1;
          end else if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= ST_RD_R;
          end
        end
        ST_RD_R: begin
          if (m_axi_rvalid) begin
            rdata        <= m_axi_rdata;
            resp         <= m_axi_rresp;
            m_axi_rready <= 1'b0;
            ack          <= ack_vec;
            state        <= ST_DONE;
          end
        end
        ST_LOCAL_ERR: begin
          rdata <= '0;
          resp  <= AXI_DECERR;
          ack   <= ack_vec;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cardio_axil_arbiter.sv
// Randomised bench for cardio_axil_arbiter with an AXI4-Lite slave model.
// Reference model: register array, round-robin rule, latency rules.
module tb_cardio_axil_arbiter;

  localparam int AW = 6;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic [1:0]    req = '0;
  logic [1:0]    we = '0;
  logic [2*AW-1:0] addr = '0;
  logic [63:0]   wdata = '0;
  logic [7:0]    wstrb = '0;
  logic [1:0]    ack;
  logic [31:0]   rdata;
  logic [1:0]    resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready;
  logic [31:0]   m_wdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready;
  logic [31:0]   m_rdata;
  logic          rvalid, rready;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  cardio_axil_arbiter dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .req(req), .we(we), .addr(addr),
    .wdata(wdata), .wstrb(wstrb),
    .ack(ack), .rdata(rdata), .resp(resp),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(m_rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  // ---------------- AXI4-Lite slave model ----------------
  logic [31:0]   smem [4];
  int            aw_lat = 0;
  int            w_lat = 0;
  logic [1:0]    force_bresp = 2'b00;
  bit            r_hold = 1'b0;
  int            aw_cnt, w_cnt;
  logic          got_aw, got_w, r_pend;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wstrb;
  int            n_aw = 0, n_w = 0, n_ar = 0;
  logic          aw_hs, w_hs, ar_hs, aw_have, w_have;
  logic [AW-1:0] cur_awaddr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wstrb;

  assign awready = awvalid && (aw_cnt >= aw_lat);
  assign wready  = wvalid && (w_cnt >= w_lat);
  assign arready = arvalid;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign ar_hs   = arvalid && arready;
  assign aw_have = got_aw || aw_hs;
  assign w_have  = got_w || w_hs;
  assign cur_awaddr = got_aw ? s_awaddr : awaddr;
  assign cur_wdata  = got_w ? s_wdata : m_wdata;
  assign cur_wstrb  = got_w ? s_wstrb : m_wstrb;

  always @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_cnt <= 0; w_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0; r_pend <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0;
      bresp <= 2'b00; rresp <= 2'b00; m_rdata <= '0;
      s_awaddr <= '0; s_araddr <= '0;
      s_wdata <= '0; s_wstrb <= '0;
      for (int k = 0; k < 4; k++) smem[k] <= '0;
    end else begin
      if (awvalid && !awready) aw_cnt <= aw_cnt + 1;
      else if (aw_hs) aw_cnt <= 0;
      if (wvalid && !wready) w_cnt <= w_cnt + 1;
      else if (w_hs) w_cnt <= 0;
      if (aw_hs) begin
        n_aw <= n_aw + 1;
        s_awaddr <= awaddr;
      end
      if (w_hs) begin
        n_w <= n_w + 1;
        s_wdata <= m_wdata;
        s_wstrb <= m_wstrb;
      end
      if (aw_have && w_have && !bvalid) begin
        for (int b = 0; b < 4; b++)
          if (cur_wstrb[b])
            smem[cur_awaddr[3:2]][8*b +: 8] <= cur_wdata[8*b +: 8];
        bvalid <= 1'b1;
        bresp  <= force_bresp;
        got_aw <= 1'b0;
        got_w  <= 1'b0;
      end else begin
        if (aw_hs) got_aw <= 1'b1;
        if (w_hs)  got_w  <= 1'b1;
      end
      if (bvalid && bready) bvalid <= 1'b0;
      if (ar_hs) begin
        n_ar <= n_ar + 1;
        s_araddr <= araddr;
        if (r_hold) begin
          r_pend <= 1'b1;
        end else begin
          rvalid  <= 1'b1;
          m_rdata <= smem[araddr[3:2]];
          rresp   <= 2'b00;
        end
      end
      if (r_pend && !r_hold) begin
        rvalid  <= 1'b1;
        m_rdata <= smem[s_araddr[3:2]];
        rresp   <= 2'b00;
        r_pend  <= 1'b0;
      end
      if (rvalid && rready) rvalid <= 1'b0;
    end
  end

  // ---------------- protocol watch ----------------
  logic          p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0, p_rst = 1'b0;
  logic [AW-1:0] p_awaddr, p_araddr;
  logic [31:0]   p_wdata;
  logic [3:0]    p_wstrb;

  always @(negedge ACLK) begin
    if (ARESETN && p_rst) begin
      if (p_aw) begin
        checks++;
        if (!(awvalid && awaddr == p_awaddr)) begin
          errors++;
          $display("FAIL aw_hold: awvalid=%0b awaddr=%h need 1/%h",
                   awvalid, awaddr, p_awaddr);
        end
      end
      if (p_w) begin
        checks++;
        if (!(wvalid && m_wdata == p_wdata && m_wstrb == p_wstrb)) begin
          errors++;
          $display("FAIL w_hold: wvalid=%0b wdata=%h need 1/%h",
                   wvalid, m_wdata, p_wdata);
        end
      end
      if (p_ar) begin
        checks++;
        if (!(arvalid && araddr == p_araddr)) begin
          errors++;
          $display("FAIL ar_hold: arvalid=%0b araddr=%h need 1/%h",
                   arvalid, araddr, p_araddr);
        end
      end
      if (awvalid || arvalid) begin
        checks++;
        if (awprot !== 3'b000 || arprot !== 3'b000) begin
          errors++;
          $display("FAIL prot: aw=%b ar=%b need 000", awprot, arprot);
        end
      end
    end
    p_aw = awvalid && !awready;
    p_w  = wvalid && !wready;
    p_ar = arvalid && !arready;
    p_awaddr = awaddr;
    p_araddr = araddr;
    p_wdata  = m_wdata;
    p_wstrb  = m_wstrb;
    p_rst    = ARESETN;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [4];
  bit          ref_last;
  logic [31:0] ref_rdata;
  bit          op_w [2];
  int          op_a [2];
  logic [31:0] op_d [2];
  logic [3:0]  op_s [2];

  function automatic bit in_range(int a);
    return (a < 16) && (a % 4 == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) ref_mem[k] = '0;
    ref_last  = 1'b1;
    ref_rdata = '0;
  endtask

  task automatic model_apply(input int i, output logic [31:0] er,
                             output logic [1:0] es);
    int a;
    a = op_a[i];
    if (!in_range(a)) begin
      er = '0;
      es = 2'b11;
    end else if (op_w[i]) begin
      for (int b = 0; b < 4; b++)
        if (op_s[i][b]) ref_mem[a/4][8*b +: 8] = op_d[i][8*b +: 8];
      er = ref_rdata;
      es = force_bresp;
    end else begin
      er = ref_mem[a/4];
      es = 2'b00;
    end
    ref_rdata = er;
    ref_last  = (i == 1);
  endtask

  task automatic set_op(input int i, input bit w, input int a,
                        input logic [31:0] d, input logic [3:0] s);
    op_w[i] = w; op_a[i] = a; op_d[i] = d; op_s[i] = s;
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = AW'(a);
    wdata[i*32 +: 32] = d;
    wstrb[i*4 +: 4]   = s;
  endtask

  task automatic apply_reset();
    @(negedge ACLK);
    ARESETN = 1'b0;
    req = '0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    model_reset();
  endtask

  // waits for the next ack, checks grantee/rdata/resp, retires that op
  task automatic serve_one(output int who, output int lat);
    int          exp_i;
    logic [31:0] er;
    logic [1:0]  es;
    exp_i = (req == 2'b11) ? (ref_last ? 0 : 1) : (req[1] ? 1 : 0);
    who = -1;
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge ACLK);
      if (ack != 2'b00) begin
        lat = c;
        who = ack[1] ? 1 : 0;
        break;
      end
    end
    checks++;
    if (who < 0) begin
      errors++;
      $display("FAIL ack_timeout: no ack in 60 cycles, req=%b", req);
      return;
    end
    if (ack !== (exp_i == 1 ? 2'b10 : 2'b01)) begin
      errors++;
      $display("FAIL grant: ack=%b need requester %0d", ack, exp_i);
    end
    who = exp_i;
    model_apply(exp_i, er, es);
    checks++;
    if (rdata !== er || resp !== es) begin
      errors++;
      $display("FAIL data: rdata=%h resp=%b need %h/%b (addr %h)",
               rdata, resp, er, es, op_a[exp_i]);
    end
    req[exp_i] = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    ARESETN = 1'b0;
    repeat (3) @(negedge ACLK);
    checks++;
    if ({ack, rdata, resp, awvalid, wvalid, bready, arvalid, rready}
        !== '0) begin
      errors++;
      $display("FAIL reset_outs: ack=%b rdata=%h resp=%b v=%b need 0",
               ack, rdata, resp,
               {awvalid, wvalid, bready, arvalid, rready});
    end
    ARESETN = 1'b1;
    model_reset();
    repeat (2) @(negedge ACLK);
    checks++;
    if ({ack, awvalid, arvalid} !== '0) begin
      errors++;
      $display("FAIL idle_quiet: ack=%b aw=%b ar=%b need 0",
               ack, awvalid, arvalid);
    end
  endtask

  task automatic test_single_write();
    int who, lat, aw0, w0;
    aw0 = n_aw; w0 = n_w;
    @(negedge ACLK);
    set_op(0, 1'b1, 0, 32'h0000_0001, 4'hF);
    serve_one(who, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL wr_latency: got %0d need 4", lat);
    end
    @(negedge ACLK);
    checks++;
    if (ack !== 2'b00) begin
      errors++;
      $display("FAIL ack_pulse: ack=%b need 00", ack);
    end
    checks++;
    if (n_aw - aw0 != 1 || n_w - w0 != 1) begin
      errors++;
      $display("FAIL wr_beats: aw=%0d w=%0d need 1/1",
               n_aw - aw0, n_w - w0);
    end
  endtask

  task automatic test_both_writes();
    int who, lat;
    apply_reset();
    @(negedge ACLK);
    set_op(0, 1'b1, 4, $urandom, 4'hF);
    set_op(1, 1'b1, 8, $urandom, 4'hF);
    serve_one(who, lat);
    checks++;
    if (who != 0) begin
      errors++;
      $display("FAIL rr_first: got %0d need 0", who);
    end
    serve_one(who, lat);
    checks++;
    if (who != 1) begin
      errors++;
      $display("FAIL rr_second: got %0d need 1", who);
    end
    @(negedge ACLK);
    set_op(0, 1'b0, 4, '0, '0);
    set_op(1, 1'b0, 8, '0, '0);
    serve_one(who, lat);
    serve_one(who, lat);
  endtask

  task automatic test_alternate();
    int who, lat, prev;
    @(negedge ACLK);
    set_op(1, 1'b0, 12, '0, '0);
    set_op(0, 1'b1, 4 * $urandom_range(0, 3), $urandom, 4'hF);
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      serve_one(who, lat);
      if (k > 0) begin
        checks++;
        if (who == prev) begin
          errors++;
          $display("FAIL starve: grant %0d twice in a row", who);
        end
      end
      prev = who;
      if (k < 3) begin
        if (who == 1) set_op(1, 1'b0, 12, '0, '0);
        else set_op(0, 1'b1, 4 * $urandom_range(0, 3), $urandom,
                    4'($urandom_range(1, 15)));
      end
    end
    serve_one(who, lat);
  endtask

  task automatic test_slow_slave();
    int who, lat;
    w_lat = 3;
    force_bresp = 2'b10;
    @(negedge ACLK);
    set_op(0, 1'b1, 4, $urandom, 4'($urandom_range(1, 15)));
    serve_one(who, lat);
    checks++;
    if (lat != 7) begin
      errors++;
      $display("FAIL slow_latency: got %0d need 7", lat);
    end
    w_lat = 0;
    force_bresp = 2'b00;
    @(negedge ACLK);
    set_op(1, 1'b0, 4, '0, '0);
    serve_one(who, lat);
  endtask

  task automatic test_local_err();
    int who, lat, ar0, aw0;
    int bad [3] = '{16, 2, 21};
    ar0 = n_ar; aw0 = n_aw;
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      set_op(0, (k == 2), bad[k], $urandom, 4'hF);
      serve_one(who, lat);
      checks++;
      if (lat != 2) begin
        errors++;
        $display("FAIL err_latency: addr %h got %0d need 2", bad[k], lat);
      end
    end
    checks++;
    if (n_ar != ar0 || n_aw != aw0) begin
      errors++;
      $display("FAIL err_traffic: ar=%0d aw=%0d need 0/0",
               n_ar - ar0, n_aw - aw0);
    end
  endtask

  task automatic test_reset_midread();
    int who, lat;
    bit seen;
    r_hold = 1'b1;
    @(negedge ACLK);
    set_op(0, 1'b0, 12, '0, '0);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ACLK);
      if (rready) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rd_r_reach: rready=%b need 1", rready);
    end
    ARESETN = 1'b0;
    req = '0;
    @(negedge ACLK);
    checks++;
    if ({ack, rdata, resp, awvalid, wvalid, bready, arvalid, rready}
        !== '0) begin
      errors++;
      $display("FAIL midreset_outs: ack=%b rdata=%h resp=%b v=%b need 0",
               ack, rdata, resp,
               {awvalid, wvalid, bready, arvalid, rready});
    end
    ARESETN = 1'b1;
    r_hold = 1'b0;
    model_reset();
    @(negedge ACLK);
    set_op(0, 1'b0, 0, '0, '0);
    serve_one(who, lat);
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL rd_latency: got %0d need 4", lat);
    end
  endtask

  task automatic test_random();
    int who, lat, n, a;
    bit single;
    for (int it = 0; it < 24; it++) begin
      @(negedge ACLK);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 2; i++) begin
        if (n[i]) begin
          a = $urandom_range(0, 23);
          set_op(i, 1'($urandom), a, $urandom,
                 4'($urandom_range(0, 15)));
        end
      end
      single = (n != 3);
      a = op_a[n[1] && !n[0] ? 1 : 0];
      serve_one(who, lat);
      if (single) begin
        checks++;
        if (lat != (in_range(a) ? 4 : 2)) begin
          errors++;
          $display("FAIL rnd_latency: addr %h got %0d need %0d",
                   a, lat, in_range(a) ? 4 : 2);
        end
      end
      while (req != 2'b00) serve_one(who, lat);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_write();
    test_both_writes();
    test_alternate();
    test_slow_slave();
    test_local_err();
    test_reset_midread();
    test_random();
    repeat (2) @(negedge ACLK);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
